// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must stay at least one bit wide even when a single digit covers the word.
  function automatic int cnt_width(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_rca.sv
// One DIGIT-bit ripple slice using mux carry selection.
module digit_rca #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             c_in,
  output logic [DIGIT-1:0] sum,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [DIGIT:0] c;

  // Propagate selects the incoming carry; otherwise a_i == b_i is the generate/kill value.
  always_comb begin
    c   = '0;
    sum = '0;
    c[0] = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] ^ b[i]) ? c[i] : a[i];
    end
  end

  assign c_out    = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: one DIGIT-bit slice per cycle, valid/ready on both sides.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  if (WIDTH % DIGIT != 0) begin : g_width_chk
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] a_dig, b_dig, d_sum;
  logic             d_cout, d_cmsb;
  logic             accept;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  assign a_dig = a_r[int'(cnt)*DIGIT +: DIGIT];
  assign b_dig = b_r[int'(cnt)*DIGIT +: DIGIT];

  digit_rca #(.DIGIT(DIGIT)) u_rca (
    .a        (a_dig),
    .b        (b_dig),
    .c_in     (carry_r),
    .sum      (d_sum),
    .c_out    (d_cout),
    .c_msb_in (d_cmsb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      carry_r   <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE with out_ready releases the result; a pending input is taken on the same edge.
          if (accept) begin
            a_r       <= a;
            b_r       <= b;
            carry_r   <= c_in;
            cnt       <= '0;
            state     <= BUSY;
            out_valid <= 1'b0;
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          sum[int'(cnt)*DIGIT +: DIGIT] <= d_sum;
          carry_r <= d_cout;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            c_out     <= d_cout;
            overflow  <= d_cout ^ d_cmsb;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
